// File: rtl/writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter_pkg
// Description : Functional-unit codes and writeback widths shared by the
//               register unit and every functional unit.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_arbiter_pkg;

  localparam int c_addressSize = 64;
  localparam int c_regWidth    = 5;
  localparam int c_codeWidth   = 3;
  localparam int c_numReq      = 3;

  localparam logic [c_codeWidth-1:0] c_FXUnitCode   = 3'd0;
  localparam logic [c_codeWidth-1:0] c_FPUnitCode   = 3'd1;
  localparam logic [c_codeWidth-1:0] c_LdStUnitCode = 3'd2;

  // A single requester still needs a one-bit pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_arbiter_rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin select: first valid requester at or
//               after the pointer, with wrap-around, as one-hot and index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker #(
  parameter int numReq   = 3,
  parameter int ptrWidth = 2
) (
  input  logic [numReq-1:0]   valid_i,
  input  logic [ptrWidth-1:0] ptr_i,
  output logic [numReq-1:0]   grant_o,
  output logic [ptrWidth-1:0] winner_o,
  output logic                any_o
);

  logic [2*numReq-1:0] w_valid_dbl;
  logic [numReq-1:0]   w_rotated;
  logic [ptrWidth-1:0] w_offset;
  logic [ptrWidth:0]   w_sum;

  // Rotating a doubled copy puts the pointer's requester at bit 0.
  assign w_valid_dbl = {valid_i, valid_i};
  assign w_rotated   = numReq'(w_valid_dbl >> ptr_i);

  always_comb begin
    w_offset = '0;
    for (int k = numReq - 1; k >= 0; k--) begin
      if (w_rotated[k]) begin
        w_offset = ptrWidth'(k);
      end
    end
  end

  assign w_sum    = {1'b0, ptr_i} + {1'b0, w_offset};
  assign winner_o = (w_sum >= (ptrWidth+1)'(numReq)) ? ptrWidth'(w_sum - (ptrWidth+1)'(numReq))
                                                     : ptrWidth'(w_sum);
  assign any_o    = |valid_i;
  assign grant_o  = any_o ? (numReq'(1) << winner_o) : '0;

endmodule
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Round-robin arbitration of the FX, FP and LdSt writeback beats
//               onto the register unit's single registered writeback port.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int addressSize = c_addressSize,
  parameter int regWidth    = c_regWidth,
  parameter int numReq      = c_numReq,
  parameter int codeWidth   = c_codeWidth
) (
  input  logic                          clock_i,
  input  logic                          reset_n_i,
  input  logic [numReq-1:0]             reqValid_i,
  output logic [numReq-1:0]             reqReady_o,
  input  logic [numReq*addressSize-1:0] reqReg1Data_i,
  input  logic [numReq*addressSize-1:0] reqReg2Data_i,
  input  logic [numReq*regWidth-1:0]    reqReg1Addr_i,
  input  logic [numReq*regWidth-1:0]    reqReg2Addr_i,
  input  logic [numReq-1:0]             reqReg1En_i,
  input  logic [numReq-1:0]             reqReg2En_i,
  input  logic [numReq-1:0]             reqIs64Bit_i,
  output logic [codeWidth-1:0]          regWritebackFunctionalUnitCode_o,
  output logic [addressSize-1:0]        reg1WritebackData_o,
  output logic [addressSize-1:0]        reg2WritebackData_o,
  output logic [regWidth-1:0]           reg1WritebackAddress_o,
  output logic [regWidth-1:0]           reg2WritebackAddress_o,
  output logic                          reg1isWriteback_o,
  output logic                          reg2isWriteback_o,
  output logic                          is64Bit_o,
  output logic                          grantValid_o
);

  localparam int c_ptrWidth = ptr_width(numReq);

  logic [addressSize-1:0] w_data1 [numReq];
  logic [addressSize-1:0] w_data2 [numReq];
  logic [regWidth-1:0]    w_addr1 [numReq];
  logic [regWidth-1:0]    w_addr2 [numReq];

  logic [numReq-1:0]     w_grant;
  logic [c_ptrWidth-1:0] w_winner;
  logic [c_ptrWidth-1:0] w_next_ptr;
  logic                  w_any;

  logic [c_ptrWidth-1:0]  r_ptr;
  logic [codeWidth-1:0]   r_code;
  logic [addressSize-1:0] r_data1;
  logic [addressSize-1:0] r_data2;
  logic [regWidth-1:0]    r_addr1;
  logic [regWidth-1:0]    r_addr2;
  logic                   r_wb1;
  logic                   r_wb2;
  logic                   r_is64;
  logic                   r_valid;

  generate
    for (genvar g = 0; g < numReq; g++) begin : g_unpack
      assign w_data1[g] = reqReg1Data_i[g*addressSize +: addressSize];
      assign w_data2[g] = reqReg2Data_i[g*addressSize +: addressSize];
      assign w_addr1[g] = reqReg1Addr_i[g*regWidth +: regWidth];
      assign w_addr2[g] = reqReg2Addr_i[g*regWidth +: regWidth];
    end
  endgenerate

  rr_priority_picker #(
    .numReq  (numReq),
    .ptrWidth(c_ptrWidth)
  ) u_picker (
    .valid_i (reqValid_i),
    .ptr_i   (r_ptr),
    .grant_o (w_grant),
    .winner_o(w_winner),
    .any_o   (w_any)
  );

  assign w_next_ptr = (w_winner == c_ptrWidth'(numReq - 1)) ? '0 : c_ptrWidth'(w_winner + 1'b1);

  // No beat may be accepted while reset is asserted.
  assign reqReady_o = reset_n_i ? w_grant : '0;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ptr   <= '0;
      r_code  <= '0;
      r_data1 <= '0;
      r_data2 <= '0;
      r_addr1 <= '0;
      r_addr2 <= '0;
      r_wb1   <= 1'b0;
      r_wb2   <= 1'b0;
      r_is64  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_any) begin
      r_ptr   <= w_next_ptr;
      r_code  <= codeWidth'(w_winner);
      r_data1 <= w_data1[w_winner];
      r_data2 <= w_data2[w_winner];
      r_addr1 <= w_addr1[w_winner];
      r_addr2 <= w_addr2[w_winner];
      r_wb1   <= reqReg1En_i[w_winner];
      r_wb2   <= reqReg2En_i[w_winner];
      r_is64  <= reqIs64Bit_i[w_winner];
      r_valid <= 1'b1;
    end else begin
      // Idle: payload holds, only the liveness flags drop.
      r_wb1   <= 1'b0;
      r_wb2   <= 1'b0;
      r_valid <= 1'b0;
    end
  end

  assign regWritebackFunctionalUnitCode_o = r_code;
  assign reg1WritebackData_o              = r_data1;
  assign reg2WritebackData_o              = r_data2;
  assign reg1WritebackAddress_o           = r_addr1;
  assign reg2WritebackAddress_o           = r_addr2;
  assign reg1isWriteback_o                = r_wb1;
  assign reg2isWriteback_o                = r_wb2;
  assign is64Bit_o                        = r_is64;
  assign grantValid_o                     = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_arbiter
// Description : Directed bench for writeback_arbiter with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;

  localparam int N  = 3;
  localparam int AS = 64;
  localparam int RW = 5;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    valid;
  logic [N-1:0]    ready;
  logic [N*AS-1:0] d1_in, d2_in;
  logic [N*RW-1:0] a1_in, a2_in;
  logic [N-1:0]    e1_in, e2_in, b64_in;
  logic [CW-1:0]   code;
  logic [AS-1:0]   d1, d2;
  logic [RW-1:0]   a1, a2;
  logic            f1, f2, is64, gv;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  writeback_arbiter #(
    .addressSize(AS), .regWidth(RW), .numReq(N), .codeWidth(CW)
  ) dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .reqValid_i(valid), .reqReady_o(ready),
    .reqReg1Data_i(d1_in), .reqReg2Data_i(d2_in),
    .reqReg1Addr_i(a1_in), .reqReg2Addr_i(a2_in),
    .reqReg1En_i(e1_in), .reqReg2En_i(e2_in), .reqIs64Bit_i(b64_in),
    .regWritebackFunctionalUnitCode_o(code),
    .reg1WritebackData_o(d1), .reg2WritebackData_o(d2),
    .reg1WritebackAddress_o(a1), .reg2WritebackAddress_o(a2),
    .reg1isWriteback_o(f1), .reg2isWriteback_o(f2),
    .is64Bit_o(is64), .grantValid_o(gv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int pick(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  int           m_ptr;
  int           m_win;
  logic [CW-1:0] m_code;
  logic [AS-1:0] m_d1, m_d2;
  logic [RW-1:0] m_a1, m_a2;
  logic          m_f1, m_f2, m_b64, m_gv;

  always @* m_win = pick(m_ptr, valid);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0; m_code <= '0; m_d1 <= '0; m_d2 <= '0; m_a1 <= '0; m_a2 <= '0;
      m_f1 <= 1'b0; m_f2 <= 1'b0; m_b64 <= 1'b0; m_gv <= 1'b0;
    end else if (m_win >= 0) begin
      m_ptr  <= (m_win + 1) % N;
      m_code <= CW'(m_win);
      m_d1   <= d1_in[m_win*AS +: AS];
      m_d2   <= d2_in[m_win*AS +: AS];
      m_a1   <= a1_in[m_win*RW +: RW];
      m_a2   <= a2_in[m_win*RW +: RW];
      m_f1   <= e1_in[m_win];
      m_f2   <= e2_in[m_win];
      m_b64  <= b64_in[m_win];
      m_gv   <= 1'b1;
    end else begin
      m_f1 <= 1'b0; m_f2 <= 1'b0; m_gv <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", ready, (!rst_n || m_win < 0) ? 3'b000 : N'(1 << m_win));
      chk("grant_valid", gv, m_gv);
      chk("code", code, m_code);
      chk("data1", d1, m_d1);
      chk("data2", d2, m_d2);
      chk("addr1", a1, m_a1);
      chk("addr2", a2, m_a2);
      chk("wb1", f1, m_f1);
      chk("wb2", f2, m_f2);
      chk("is64", is64, m_b64);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_all();
    valid = '0; e1_in = '0; e2_in = '0; b64_in = '0;
  endtask

  task automatic load(input int u, input logic [AS-1:0] x1, input logic [RW-1:0] r1,
                      input logic [AS-1:0] x2, input logic [RW-1:0] r2,
                      input logic en1, input logic en2, input logic w64);
    d1_in[u*AS +: AS] = x1;
    d2_in[u*AS +: AS] = x2;
    a1_in[u*RW +: RW] = r1;
    a2_in[u*RW +: RW] = r2;
    e1_in[u] = en1; e2_in[u] = en2; b64_in[u] = w64;
    valid[u] = 1'b1;
  endtask

  int order[$];
  int exp_order[6] = '{0, 1, 2, 0, 1, 2};
  logic [2:0] pats[8] = '{3'b111, 3'b101, 3'b010, 3'b000, 3'b110, 3'b011, 3'b100, 3'b111};

  initial begin
    rst_n = 1'b1;
    d1_in = '0; d2_in = '0; a1_in = '0; a2_in = '0;
    clear_all();
    #1 rst_n = 1'b0;
    for (int u = 0; u < N; u++) load(u, 64'h100 + 64'(u), 5'(u + 1), 64'h200 + 64'(u), 5'(u + 8), 1'b1, 1'b1, 1'b1);
    #1 cmp_en = 1'b1;

    // Reset with all requesters valid
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", ready, 3'b000);
    chk("reset_gv", gv, 1'b0);
    chk("reset_flags", {f1, f2}, 2'b00);
    #1 rst_n = 1'b1;
    #1 chk("first_grant", ready, 3'b001);
    #1;

    // All three valid for six cycles
    repeat (6) begin
      @(posedge clk); #1;
      chk("rr_gv", gv, 1'b1);
      order.push_back(int'(code));
    end
    for (int i = 0; i < 6; i++) chk("rr_order", 64'(order[i]), 64'(exp_order[i]));
    #1 clear_all();

    // Single LdSt beat
    load(2, 64'hAA, 5'd3, 64'hBB, 5'd4, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("ldst_code", code, 3'd2);
    chk("ldst_flags", {f1, f2}, 2'b11);
    chk("ldst_data1", d1, 64'hAA);
    chk("ldst_data2", d2, 64'hBB);
    chk("ldst_addrs", {a1, a2}, {5'd3, 5'd4});
    chk("ldst_gv", gv, 1'b1);
    #1 clear_all();
    @(posedge clk); #1;
    chk("ldst_gv_drop", gv, 1'b0);

    // Pointer to 2, then 0 and 2 compete
    #1 load(1, 64'h11, 5'd1, 64'h12, 5'd2, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("fp_code", code, 3'd1);
    #1 clear_all();
    load(0, 64'h21, 5'd5, 64'h22, 5'd6, 1'b1, 1'b1, 1'b0);
    load(2, 64'h31, 5'd7, 64'h32, 5'd8, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("wrap_first", code, 3'd2);
    #1 valid[2] = 1'b0;
    @(posedge clk); #1;
    chk("wrap_second", code, 3'd0);
    #1 clear_all();
    for (int u = 0; u < N; u++) load(u, 64'h40 + 64'(u), 5'(u), 64'h50 + 64'(u), 5'(u), 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("ptr_after_wrap", code, 3'd1);
    #1 clear_all();

    // FX beat with only slot 2 enabled, then idle
    load(0, 64'h1234, 5'd7, 64'h5678, 5'd9, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("fx_flags", {f1, f2}, 2'b01);
    chk("fx_code", code, 3'd0);
    chk("fx_data2", d2, 64'h5678);
    #1 clear_all();
    @(posedge clk); #1;
    chk("idle_flags", {f1, f2, gv}, 3'b000);
    chk("idle_data_held", d1, 64'h1234);

    // Reset while a beat sits in the output register
    #1 load(1, 64'h77, 5'd10, 64'h88, 5'd11, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("pre_reset_gv", gv, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_flags", {f1, f2, gv}, 3'b000);
    chk("async_ready", ready, 3'b000);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("retry_ready", ready, 3'b010);
    @(posedge clk); #1;
    chk("retry_code", {gv, code}, {1'b1, 3'd1});
    #1 clear_all();

    // Mixed request patterns checked by the model
    for (int s = 0; s < 8; s++) begin
      for (int u = 0; u < N; u++) begin
        if (pats[s][u]) load(u, 64'(s * 16 + u), 5'(s + u), 64'(s * 256 + u), 5'(s * 2 + u),
                             (s + u) % 2 == 0, (s + u) % 3 != 0, u == 1);
      end
      @(posedge clk); #2;
      clear_all();
    end

    repeat (2) @(posedge clk);
    #1 cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
